// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer: CTRL/PRESET/COUNT window at BASE, one-shot interrupt.
// Build option: define MMIO_TIMER_AUTORELOAD_EN to make MODE=1 reload and restart after each expiry.
module mmio_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

`ifdef MMIO_TIMER_AUTORELOAD_EN
    localparam logic AUTORELOAD = 1'b1;
`else
    localparam logic AUTORELOAD = 1'b0;
`endif

    localparam logic [29:0] WORD_CTRL   = BASE[31:2];
    localparam logic [29:0] WORD_PRESET = BASE[31:2] + 30'd1;
    localparam logic [29:0] WORD_COUNT  = BASE[31:2] + 30'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state_r;
    logic [3:0]  ctrl_r;
    logic [31:0] preset_r;
    logic [31:0] count_r;

    logic        sel_ctrl_s;
    logic        sel_preset_s;
    logic        sel_count_s;
    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        auto_s;
    logic [31:0] ctrl_wr_s;
    logic [31:0] preset_wr_s;
    logic        unused_s;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Address decode and byte-merged write data; a write with no lanes enabled is not a write.
    always_comb begin
        sel_ctrl_s   = (addr[31:2] == WORD_CTRL);
        sel_preset_s = (addr[31:2] == WORD_PRESET);
        sel_count_s  = (addr[31:2] == WORD_COUNT);
        wr_ctrl_s    = we & sel_ctrl_s & (|byteen);
        wr_preset_s  = we & sel_preset_s & (|byteen);
        ctrl_wr_s    = merge_bytes({28'd0, ctrl_r}, wdata, byteen);
        preset_wr_s  = merge_bytes(preset_r, wdata, byteen);
        auto_s       = AUTORELOAD & (ctrl_r[2:1] == 2'b01);
    end

    assign unused_s = ^{addr[1:0], ctrl_wr_s[31:4]};

    // Read mux reflects the registers as they stood before the coming edge.
    always_comb begin
        rdata = 32'd0;
        case (1'b1)
            sel_ctrl_s:   rdata = {28'd0, ctrl_r};
            sel_preset_s: rdata = preset_r;
            sel_count_s:  rdata = count_r;
            default:      rdata = 32'd0;
        endcase
    end

    // Interrupt comes purely from registered state and the mask bit.
    always_comb begin
        irq = ctrl_r[3] & (state_r == ST_INT);
    end

    // Timer FSM and register file; a CPU CTRL write is assigned last so it overrides the FSM's EN clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            ctrl_r   <= 4'd0;
            preset_r <= 32'd0;
            count_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ctrl_r[0]) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    count_r <= preset_r;
                    state_r <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_r[0]) begin
                        state_r <= ST_IDLE;
                    end else if (count_r > 32'd1) begin
                        count_r <= count_r - 32'd1;
                    end else begin
                        // PRESET of 0 lands here too, so it expires exactly like PRESET of 1.
                        count_r <= 32'd0;
                        state_r <= ST_INT;
                        if (!auto_s) begin
                            ctrl_r[0] <= 1'b0;
                        end
                    end
                end
                ST_INT: begin
                    if (auto_s) begin
                        state_r <= ST_LOAD;
                    end else if (wr_ctrl_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_INT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            if (wr_ctrl_s) begin
                ctrl_r <= ctrl_wr_s[3:0];
            end
            if (wr_preset_s) begin
                preset_r <= preset_wr_s;
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed vector table, corner sequences, random vs reference model.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef MMIO_TIMER_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 idle, 1 load, 2 counting, 3 expired
    logic [31:0] m_ctrl, m_preset, m_count;
    int          m_phase;

    mmio_timer #(.BASE(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  off;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:2] == BASE[31:2])         return m_ctrl & 32'hF;
        if (a[31:2] == BASE[31:2] + 30'd1) return m_preset;
        if (a[31:2] == BASE[31:2] + 30'd2) return m_count;
        return 32'd0;
    endfunction

    task automatic model_edge();
        logic [31:0] n_ctrl, n_preset, n_count;
        int          n_ph;
        bit          wrc, wrp, au;
        if (!reset) begin
            m_ctrl = 32'd0; m_preset = 32'd0; m_count = 32'd0; m_phase = 0;
            return;
        end
        wrc = we && (byteen != 4'd0) && (addr[31:2] == BASE[31:2]);
        wrp = we && (byteen != 4'd0) && (addr[31:2] == BASE[31:2] + 30'd1);
        au  = AUTO && (((m_ctrl >> 1) & 32'd3) == 32'd1);
        n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count; n_ph = m_phase;
        if (m_phase == 0) begin
            if (m_ctrl[0]) n_ph = 1;
        end else if (m_phase == 1) begin
            n_count = m_preset;
            n_ph = 2;
        end else if (m_phase == 2) begin
            if (!m_ctrl[0]) n_ph = 0;
            else if (m_count > 32'd1) n_count = m_count - 32'd1;
            else begin
                n_count = 32'd0;
                n_ph = 3;
                if (!au) n_ctrl[0] = 1'b0;
            end
        end else begin
            if (au) n_ph = 1;
            else if (wrc) n_ph = 0;
        end
        if (wrc) n_ctrl = lane_merge(m_ctrl, wdata, byteen) & 32'hF;
        if (wrp) n_preset = lane_merge(m_preset, wdata, byteen);
        m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_phase = n_ph;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        reset = r; we = w; addr = a; byteen = be; wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, a, 4'h0, 32'd0);
        #1;
        chk(nm, rdata, exp);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  be;
        logic        r, w;
        logic        found;
        int          sel;

        vt[0]  = '{1'b1, 4'd4, 4'hF, 32'd5, 32'd0, 1'b0};
        vt[1]  = '{1'b1, 4'd0, 4'hF, 32'd9, 32'd0, 1'b0};
        vt[2]  = '{1'b0, 4'd8, 4'h0, 32'd0, 32'd0, 1'b0};
        vt[3]  = '{1'b0, 4'd8, 4'h0, 32'd0, 32'd0, 1'b0};
        vt[4]  = '{1'b0, 4'd8, 4'h0, 32'd0, 32'd5, 1'b0};
        vt[5]  = '{1'b0, 4'd8, 4'h0, 32'd0, 32'd4, 1'b0};
        vt[6]  = '{1'b0, 4'd8, 4'h0, 32'd0, 32'd3, 1'b0};
        vt[7]  = '{1'b0, 4'd8, 4'h0, 32'd0, 32'd2, 1'b0};
        vt[8]  = '{1'b0, 4'd8, 4'h0, 32'd0, 32'd1, 1'b0};
        vt[9]  = '{1'b0, 4'd8, 4'h0, 32'd0, 32'd0, 1'b1};
        vt[10] = '{1'b0, 4'd0, 4'h0, 32'd0, 32'd8, 1'b1};
        vt[11] = '{1'b0, 4'd0, 4'h0, 32'd0, 32'd8, 1'b1};
        vt[12] = '{1'b1, 4'd0, 4'hF, 32'd0, 32'd8, 1'b1};
        vt[13] = '{1'b0, 4'd8, 4'h0, 32'd0, 32'd0, 1'b0};
        vt[14] = '{1'b0, 4'd4, 4'h0, 32'd0, 32'd5, 1'b0};
        vt[15] = '{1'b0, 4'd0, 4'h0, 32'd0, 32'd0, 1'b0};

        // reset state
        drive(1'b0, 1'b0, BASE, 4'h0, 32'd0);
        tick();
        tick();
        rd_chk("rst_ctrl", BASE, 32'd0);
        rd_chk("rst_preset", BASE + 32'd4, 32'd0);
        rd_chk("rst_count", BASE + 32'd8, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // one-shot count from 5, then software clears CTRL
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vt[i].we, BASE + {28'd0, vt[i].off}, vt[i].be, vt[i].wdata);
            #1;
            chk($sformatf("vec%0d_rd", i), rdata, vt[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vt[i].exp_irq});
            tick();
        end

        // PRESET=0 expires three edges after the CTRL write; COUNT is not writable
        drive(1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'd0); tick();
        drive(1'b1, 1'b1, BASE, 4'hF, 32'd9); tick();
        rd_chk("p0_e0_cnt", BASE + 32'd8, 32'd0);
        chk("p0_e0_irq", {31'd0, irq}, 32'd0);
        tick(); chk("p0_e1_irq", {31'd0, irq}, 32'd0);
        tick(); chk("p0_e2_irq", {31'd0, irq}, 32'd0);
        tick(); chk("p0_e3_irq", {31'd0, irq}, 32'd1);
        drive(1'b1, 1'b1, BASE + 32'd8, 4'hF, 32'h1234); tick();
        rd_chk("p0_count_ro", BASE + 32'd8, 32'd0);
        chk("p0_irq_held", {31'd0, irq}, 32'd1);
        drive(1'b1, 1'b1, BASE, 4'hF, 32'd0); tick();
        chk("p0_irq_clr", {31'd0, irq}, 32'd0);

        // empty byteen is no write; clearing EN stops the count and holds it
        drive(1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'd100); tick();
        drive(1'b1, 1'b1, BASE, 4'hF, 32'd9); tick();
        drive(1'b1, 1'b0, BASE + 32'd8, 4'h0, 32'd0); tick(); tick();
        rd_chk("be_cnt100", BASE + 32'd8, 32'd100);
        drive(1'b1, 1'b1, BASE, 4'h0, 32'd0); tick();
        rd_chk("be0_ctrl", BASE, 32'd9);
        rd_chk("be0_cnt", BASE + 32'd8, 32'd99);
        drive(1'b1, 1'b1, BASE, 4'h1, 32'd0); tick();
        rd_chk("be1_cnt", BASE + 32'd8, 32'd98);
        tick(); tick(); tick();
        rd_chk("be1_hold", BASE + 32'd8, 32'd98);
        rd_chk("be1_ctrl", BASE, 32'd0);
        chk("be1_irq", {31'd0, irq}, 32'd0);

        // reset mid-count beats a coincident PRESET write
        drive(1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'd5); tick();
        drive(1'b1, 1'b1, BASE, 4'hF, 32'd9); tick();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            rd_chk_nocount: begin
                drive(1'b1, 1'b0, BASE + 32'd8, 4'h0, 32'd0);
                #1;
                if (rdata == 32'd2) found = 1'b1;
                else tick();
            end
        end
        chk("rst_mid_reach2", {31'd0, found}, 32'd1);
        drive(1'b0, 1'b1, BASE + 32'd4, 4'hF, 32'hFFFF_FFFF); tick();
        rd_chk("rstm_ctrl", BASE, 32'd0);
        rd_chk("rstm_preset", BASE + 32'd4, 32'd0);
        rd_chk("rstm_count", BASE + 32'd8, 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rstm_irq%0d", k), {31'd0, irq}, 32'd0);
            tick();
        end

        // MODE=1: periodic 1-cycle pulse with autoreload, held irq without
        drive(1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'd3); tick();
        drive(1'b1, 1'b1, BASE, 4'hF, 32'hB); tick();
        drive(1'b1, 1'b0, BASE, 4'h0, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("ar_irq%0d", k), {31'd0, irq},
                AUTO ? {31'd0, (k % 5 == 0)} : {31'd0, (k >= 5)});
        end
        rd_chk("ar_ctrl", BASE, AUTO ? 32'hB : 32'hA);

        // randomized traffic against the reference model
        drive(1'b0, 1'b0, BASE, 4'h0, 32'd0); tick();
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 149) != 0);
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1, 2: a = BASE + 32'(4 * sel);
                3:       a = BASE + 32'd12;
                4:       a = BASE - 32'd4;
                default: a = $urandom;
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            w  = ($urandom_range(0, 3) == 0);
            be = 4'($urandom_range(0, 15));
            d  = (sel == 1) ? 32'($urandom_range(0, 6)) : $urandom;
            drive(r, w, a, be, d);
            #1;
            chk($sformatf("rnd%0d_rd", n), rdata, model_read(a));
            chk($sformatf("rnd%0d_irq", n), {31'd0, irq},
                {31'd0, (m_ctrl[3] && m_phase == 3)});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
